program_memory_loader: RTL

Controller that shares the instruction memory between the MIPS fetch path and a serial byte-stream loader. In normal operation it translates the CPU program counter (text segment base 0x0040_0000) into a word index for the instruction memory. When a load frame arrives, it holds the CPU, assembles big-endian 32-bit words, and writes them sequentially from index 0. It then releases the CPU with a one-cycle restart pulse. It sits between the UART receiver, the PC register and a writable instruction memory.

---
 rtl/program_memory_loader_if.sv | 31 +++
 rtl/program_memory_loader.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/program_memory_loader_if.sv
// Bundle of the receiver handshake, PC and instruction-memory/CPU-control signals
// shared between the program loader (slave) and its surroundings (master).
interface program_memory_loader_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
);
    logic                  rx_valid;
    logic [7:0]            rx_data;
    logic                  rx_ready;
    logic [DATA_WIDTH-1:0] pc;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  cpu_hold;
    logic                  cpu_restart;
    logic                  fetch_fault;
    logic                  load_error;
    logic [ADDR_WIDTH:0]   words_loaded;

    modport master (
        output rx_valid, rx_data, pc,
        input  rx_ready, mem_addr, mem_we, mem_wdata, cpu_hold, cpu_restart,
               fetch_fault, load_error, words_loaded
    );

    modport slave (
        input  rx_valid, rx_data, pc,
        output rx_ready, mem_addr, mem_we, mem_wdata, cpu_hold, cpu_restart,
               fetch_fault, load_error, words_loaded
    );
endinterface

// File: rtl/program_memory_loader.sv
// Shares the instruction memory between CPU fetch and a serial frame loader.
// Define PROGRAM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte per frame.
module program_memory_loader #(
    parameter int                     MEMORY_DEPTH = 32,
    parameter int                     ADDR_WIDTH   = 5,
    parameter int                     DATA_WIDTH   = 32,
    parameter logic [DATA_WIDTH-1:0]  TEXT_BASE    = 32'h0040_0000
) (
    input logic                   clk,
    input logic                   reset,
    program_memory_loader_if.slave bus
);

    localparam logic [7:0]            HEADER    = 8'hA5;
    localparam logic [DATA_WIDTH-3:0] BASE_WORD = TEXT_BASE[DATA_WIDTH-1:2];
    localparam logic [DATA_WIDTH-1:0] DEPTH_W   = DATA_WIDTH'(MEMORY_DEPTH);

    typedef enum logic [2:0] {
        S_RUN,
        S_COUNT,
        S_DATA,
        S_WRITE,
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        S_CHECK,
`endif
        S_DONE,
        S_ERROR
    } state_t;

    state_t                state_reg;
    logic [7:0]            count_reg;
    logic [ADDR_WIDTH-1:0] index_reg;
    logic [ADDR_WIDTH:0]   words_reg;
    logic [DATA_WIDTH-1:0] asm_reg;
    logic [1:0]            byte_cnt_reg;
    logic                  rx_ready_reg;
    logic                  mem_we_reg;
    logic                  cpu_hold_reg;
    logic                  cpu_restart_reg;
    logic                  load_error_reg;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [7:0]            checksum_reg;
`endif

    logic                  take;
    logic [ADDR_WIDTH:0]   words_next;
    logic                  last_word;
    logic                  bad_count;
    logic [DATA_WIDTH-3:0] off_word;
    logic                  xlate_fault;

    assign take       = bus.rx_valid && rx_ready_reg;
    assign words_next = words_reg + 1'b1;
    assign last_word  = (32'(words_next) == 32'(count_reg));
    assign bad_count  = (bus.rx_data == 8'd0) || ({24'd0, bus.rx_data} > 32'(MEMORY_DEPTH));

    // TEXT_BASE is word aligned, so the word offset needs no borrow from the byte bits.
    assign off_word    = bus.pc[DATA_WIDTH-1:2] - BASE_WORD;
    assign xlate_fault = (bus.pc < TEXT_BASE) || (bus.pc[1:0] != 2'b00) ||
                         ({2'b00, off_word} >= DEPTH_W);

    assign bus.mem_addr     = cpu_hold_reg ? index_reg : off_word[ADDR_WIDTH-1:0];
    assign bus.fetch_fault  = cpu_hold_reg ? 1'b0 : xlate_fault;
    assign bus.rx_ready     = rx_ready_reg;
    assign bus.mem_we       = mem_we_reg;
    assign bus.mem_wdata    = asm_reg;
    assign bus.cpu_hold     = cpu_hold_reg;
    assign bus.cpu_restart  = cpu_restart_reg;
    assign bus.load_error   = load_error_reg;
    assign bus.words_loaded = words_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg       <= S_RUN;
            count_reg       <= 8'd0;
            index_reg       <= '0;
            words_reg       <= '0;
            asm_reg         <= '0;
            byte_cnt_reg    <= 2'd0;
            rx_ready_reg    <= 1'b1;
            mem_we_reg      <= 1'b0;
            cpu_hold_reg    <= 1'b0;
            cpu_restart_reg <= 1'b0;
            load_error_reg  <= 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            checksum_reg    <= 8'd0;
`endif
        end else begin
            mem_we_reg      <= 1'b0;
            cpu_restart_reg <= 1'b0;
            case (state_reg)
                S_RUN: begin
                    if (take && bus.rx_data == HEADER) begin
                        state_reg    <= S_COUNT;
                        cpu_hold_reg <= 1'b1;
                    end
                end
                S_COUNT: begin
                    if (take) begin
                        if (bad_count) begin
                            state_reg      <= S_ERROR;
                            load_error_reg <= 1'b1;
                        end else begin
                            state_reg    <= S_DATA;
                            count_reg    <= bus.rx_data;
                            index_reg    <= '0;
                            words_reg    <= '0;
                            byte_cnt_reg <= 2'd0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                            checksum_reg <= 8'd0;
`endif
                        end
                    end
                end
                S_DATA: begin
                    if (take) begin
                        asm_reg      <= {asm_reg[DATA_WIDTH-9:0], bus.rx_data};
                        byte_cnt_reg <= byte_cnt_reg + 2'd1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                        checksum_reg <= checksum_reg ^ bus.rx_data;
`endif
                        if (byte_cnt_reg == 2'd3) begin
                            state_reg    <= S_WRITE;
                            rx_ready_reg <= 1'b0;
                            mem_we_reg   <= 1'b1;
                        end
                    end
                end
                S_WRITE: begin
                    index_reg <= index_reg + 1'b1;
                    words_reg <= words_next;
                    if (last_word) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                        state_reg    <= S_CHECK;
                        rx_ready_reg <= 1'b1;
`else
                        state_reg       <= S_DONE;
                        cpu_restart_reg <= 1'b1;
`endif
                    end else begin
                        state_reg    <= S_DATA;
                        rx_ready_reg <= 1'b1;
                    end
                end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                S_CHECK: begin
                    if (take) begin
                        if (bus.rx_data == checksum_reg) begin
                            state_reg       <= S_DONE;
                            rx_ready_reg    <= 1'b0;
                            cpu_restart_reg <= 1'b1;
                        end else begin
                            state_reg      <= S_ERROR;
                            load_error_reg <= 1'b1;
                        end
                    end
                end
`endif
                S_DONE: begin
                    state_reg      <= S_RUN;
                    cpu_hold_reg   <= 1'b0;
                    rx_ready_reg   <= 1'b1;
                    load_error_reg <= 1'b0;
                end
                S_ERROR: begin
                    // Only a fresh header leaves ERROR; the CPU stays held meanwhile.
                    if (take && bus.rx_data == HEADER) begin
                        state_reg <= S_COUNT;
                    end
                end
                default: begin
                    state_reg <= S_RUN;
                end
            endcase
        end
    end

endmodule
